// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and dmem-side signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic        req0;
  logic        req1;
  logic [0:31] addr0;
  logic [0:31] addr1;
  logic [0:31] wData0;
  logic [0:31] wData1;
  logic        we0;
  logic        we1;
  logic [0:1]  dsize0;
  logic [0:1]  dsize1;
  logic        ack0;
  logic        ack1;
  logic [0:31] rData0;
  logic [0:31] rData1;
  logic        err0;
  logic        err1;
  logic [0:31] mem_addr;
  logic [0:31] mem_wData;
  logic        mem_writeEnable;
  logic [0:1]  mem_dsize;
  logic [0:31] mem_rData;

  modport slave (
    input  req0, req1, addr0, addr1, wData0, wData1, we0, we1, dsize0, dsize1, mem_rData,
    output ack0, ack1, rData0, rData1, err0, err1,
           mem_addr, mem_wData, mem_writeEnable, mem_dsize
  );

  modport master (
    output req0, req1, addr0, addr1, wData0, wData1, we0, we1, dsize0, dsize1,
    input  ack0, ack1, rData0, rData1, err0, err1
  );

  modport mem (
    input  mem_addr, mem_wData, mem_writeEnable, mem_dsize,
    output mem_rData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter/sequencer in front of dmem
// Optional misalignment check: DMEM_ARB_ALIGN_CHECK_EN
module dmem_arbiter (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt;
  logic [0:31] op_addr;
  logic [0:31] op_wdata;
  logic        op_we;
  logic [0:1]  op_dsize;
  logic        op_err;
  logic        mem_we_q;
  logic        ack0_q, ack1_q, err0_q, err1_q;
  logic [0:31] rdata0_q, rdata1_q;

  logic        pick;
  logic [0:31] pick_addr;
  logic [0:31] pick_wdata;
  logic        pick_we;
  logic [0:1]  pick_dsize;
  logic        misalign;

  // On a tie the port that did not win last time is served.
  assign pick       = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
  assign pick_addr  = pick ? bus.addr1  : bus.addr0;
  assign pick_wdata = pick ? bus.wData1 : bus.wData0;
  assign pick_we    = pick ? bus.we1    : bus.we0;
  assign pick_dsize = pick ? bus.dsize1 : bus.dsize0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (pick_dsize[0] && (pick_addr[30:31] != 2'b00)) ||
                    ((pick_dsize == 2'b01) && pick_addr[31]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      op_we      <= 1'b0;
      op_dsize   <= '0;
      op_err     <= 1'b0;
      mem_we_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            gnt        <= pick;
            last_grant <= pick;
            op_addr    <= pick_addr;
            op_wdata   <= pick_wdata;
            op_we      <= pick_we;
            op_dsize   <= pick_dsize;
            op_err     <= misalign;
            mem_we_q   <= pick_we & ~misalign;
            state      <= SERVE;
          end
        end
        SERVE: begin
          mem_we_q <= 1'b0;
          if (gnt) begin
            rdata1_q <= op_err ? 32'h0 : bus.mem_rData;
            ack1_q   <= 1'b1;
            err1_q   <= op_err;
          end else begin
            rdata0_q <= op_err ? 32'h0 : bus.mem_rData;
            ack0_q   <= 1'b1;
            err0_q   <= op_err;
          end
          state <= DONE;
        end
        DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          err0_q <= 1'b0;
          err1_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr        = op_addr;
  assign bus.mem_wData       = op_wdata;
  assign bus.mem_dsize       = op_dsize;
  assign bus.mem_writeEnable = mem_we_q;
  assign bus.ack0            = ack0_q;
  assign bus.ack1            = ack1_q;
  assign bus.err0            = err0_q;
  assign bus.err1            = err1_q;
  assign bus.rData0          = rdata0_q;
  assign bus.rData1          = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a byte-wide dmem model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   we_cnt = 0;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Big-endian byte memory, combinational read, write at posedge
  logic [7:0]  mem [0:511];
  logic [8:0]  ma;
  logic [0:31] mw;
  logic [0:31] rdm;
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [0:31] bd_data = '0;

  assign ma = bus.mem_addr[23:31];

  always_comb begin
    mw = {mem[ma], mem[ma + 9'd1], mem[ma + 9'd2], mem[ma + 9'd3]};
    if (bus.mem_dsize[0])          rdm = mw;
    else if (bus.mem_dsize == 2'b01) rdm = {16'h0, mw[0:15]};
    else                           rdm = {24'h0, mw[0:7]};
  end
  assign bus.mem_rData = rdm;

  always @(posedge clk) begin
    if (bus.mem_writeEnable) begin
      if (bus.mem_dsize[0]) begin
        mem[ma]         <= bus.mem_wData[0:7];
        mem[ma + 9'd1]  <= bus.mem_wData[8:15];
        mem[ma + 9'd2]  <= bus.mem_wData[16:23];
        mem[ma + 9'd3]  <= bus.mem_wData[24:31];
      end else if (bus.mem_dsize == 2'b01) begin
        mem[ma]         <= bus.mem_wData[16:23];
        mem[ma + 9'd1]  <= bus.mem_wData[24:31];
      end else begin
        mem[ma]         <= bus.mem_wData[24:31];
      end
    end else if (bd_we) begin
      mem[bd_addr]        <= bd_data[0:7];
      mem[bd_addr + 9'd1] <= bd_data[8:15];
      mem[bd_addr + 9'd2] <= bd_data[16:23];
      mem[bd_addr + 9'd3] <= bd_data[24:31];
    end
  end

  always @(negedge clk) if (bus.mem_writeEnable === 1'b1) we_cnt <= we_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] word_at(input logic [8:0] a);
    return {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  // Raise a request, wait (bounded) for its ack, drop req, return to IDLE.
  task automatic do_txn(input bit port, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic [1:0] ds,
                        output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    if (port) begin
      bus.addr1 = a; bus.wData1 = wd; bus.we1 = w; bus.dsize1 = ds; bus.req1 = 1'b1;
    end else begin
      bus.addr0 = a; bus.wData0 = wd; bus.we0 = w; bus.dsize0 = ds; bus.req0 = 1'b1;
    end
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      tick();
      if (port ? bus.ack1 : bus.ack0) begin
        lat = c;
        rd  = port ? bus.rData1 : bus.rData0;
        er  = port ? bus.err1 : bus.err0;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          we_base;

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wData0 = 0; bus.wData1 = 0;
    bus.dsize0 = 0; bus.dsize1 = 0;

    preload(9'h100, 32'hDEADBEEF);
    preload(9'h104, 32'h00112233);
    preload(9'h000, 32'h11223344);
    preload(9'h004, 32'h55667788);

    check("rst_ack0", {31'h0, bus.ack0}, 32'h0);
    check("rst_ack1", {31'h0, bus.ack1}, 32'h0);
    check("rst_err0", {31'h0, bus.err0}, 32'h0);
    check("rst_err1", {31'h0, bus.err1}, 32'h0);
    check("rst_rData0", bus.rData0, 32'h0);
    check("rst_rData1", bus.rData1, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_writeEnable}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wData", bus.mem_wData, 32'h0);
    check("rst_mem_dsize", {30'h0, bus.mem_dsize}, 32'h0);
    reset = 1'b0;

    we_base = we_cnt;
    do_txn(0, 32'h100, 32'h0, 1'b0, 2'd3, lat, rd, er);
    check("load0_latency", lat, 32'd2);
    check("load0_rData", rd, 32'hDEADBEEF);
    check("load0_err", {31'h0, er}, 32'h0);
    check("load0_no_we", we_cnt - we_base, 32'd0);

    we_base = we_cnt;
    do_txn(1, 32'h40, 32'h12345678, 1'b1, 2'd3, lat, rd, er);
    check("store1_latency", lat, 32'd2);
    check("store1_we_cycles", we_cnt - we_base, 32'd1);
    check("store1_mem", word_at(9'h040), 32'h12345678);
    do_txn(1, 32'h40, 32'h0, 1'b0, 2'd3, lat, rd, er);
    check("load1_latency", lat, 32'd2);
    check("load1_rData", rd, 32'h12345678);
    check("load1_we_cycles", we_cnt - we_base, 32'd1);
    check("rData0_held", bus.rData0, 32'hDEADBEEF);

    do_txn(0, 32'h102, 32'hCAFEF00D, 1'b1, 2'd3, lat, rd, er);
    check("mis_latency", lat, 32'd2);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check("mis_err", {31'h0, er}, 32'h1);
    check("mis_rData", rd, 32'h0);
    check("mis_mem100", word_at(9'h100), 32'hDEADBEEF);
    check("mis_mem104", word_at(9'h104), 32'h00112233);
`else
    check("mis_err", {31'h0, er}, 32'h0);
    check("mis_mem100", word_at(9'h100), 32'hDEADCAFE);
    check("mis_mem104", word_at(9'h104), 32'hF00D2233);
`endif

    bus.addr0 = 32'h80; bus.wData0 = 32'hA5A5A5A5; bus.we0 = 1'b1; bus.dsize0 = 2'd3;
    bus.req0 = 1'b1;
    tick();
    check("serve_we", {31'h0, bus.mem_writeEnable}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_serve_we", {31'h0, bus.mem_writeEnable}, 32'h0);
    tick();
    check("rst_serve_ack0", {31'h0, bus.ack0}, 32'h0);
    reset = 1'b0;
    do_txn(0, 32'h80, 32'hA5A5A5A5, 1'b1, 2'd3, lat, rd, er);
    check("regrant_latency", lat, 32'd2);
    check("regrant_mem", word_at(9'h080), 32'hA5A5A5A5);

    reset = 1'b1;
    bus.addr0 = 32'h0; bus.we0 = 1'b0; bus.dsize0 = 2'd3;
    bus.addr1 = 32'h4; bus.we1 = 1'b0; bus.dsize1 = 2'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("cont_ack0_c%0d", k), {31'h0, bus.ack0}, {31'h0, (k == 2 || k == 8)});
      check($sformatf("cont_ack1_c%0d", k), {31'h0, bus.ack1}, {31'h0, (k == 5 || k == 11)});
      if (k == 2 || k == 8)  check("cont_rData0", bus.rData0, 32'h11223344);
      if (k == 5 || k == 11) check("cont_rData1", bus.rData1, 32'h55667788);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the data memory (`dmem`). It shares the single dmem port between port 0 (pipeline load/store unit) and port 1 (debug/loader port). Grants are round-robin with one transaction outstanding. Each transaction's operands are registered, dmem is driven for exactly one cycle, and the requester receives a one-cycle acknowledge with registered read data.

## Interface
- No parameters. Memory size is owned by `dmem`; addresses pass through unmodified.

Ports (bit numbering `[0:31]`, MSB = bit 0, as in the rest of the datapath):
- `clk`  in  1  — single clock; all state changes on posedge.
- `reset`  in  1  — asynchronous, active-high.
- `req0`, `req1`  in  1  — request; held with operands stable until the matching ack is sampled.
- `addr0`, `addr1`  in  [0:31]  — byte address.
- `wData0`, `wData1`  in  [0:31]  — store data, right-justified for halfword/byte.
- `we0`, `we1`  in  1  — 1 = store, 0 = load.
- `dsize0`, `dsize1`  in  [0:1]  — bytes−1: 3 = word, 1 = halfword, 0 = byte; 2 is treated as word.
- `ack0`, `ack1`  out  1  — one-cycle completion pulse.
- `rData0`, `rData1`  out  [0:31]  — registered load data; valid while the matching ack is high.
- `err0`, `err1`  out  1  — misalignment flag, pulsed with ack (see Configuration).
- `mem_addr`  out  [0:31]  — to `dmem.addr`.
- `mem_wData`  out  [0:31]  — to `dmem.wData`.
- `mem_writeEnable`  out  1  — to `dmem.writeEnable`.
- `mem_dsize`  out  [0:1]  — to `dmem.dsize`.
- `mem_rData`  in  [0:31]  — from `dmem.rData`; combinational read.

## Operation
- The FSM has three states: IDLE → SERVE → DONE → IDLE.
- **IDLE**
  - If neither req is high, stay in IDLE.
  - Otherwise select a port:
    - Only one req high: that port wins.
    - Both high: the port that is not `last_grant` wins.
  - Latch the winner's addr, wData, we and dsize into operand registers, record the grant id, and update `last_grant`.
  - Go to SERVE.
- **SERVE**
  - `mem_addr`, `mem_wData` and `mem_dsize` are driven from the operand registers.
  - `mem_writeEnable` = latched we, unless the access is flagged as an error. dmem commits the store at the posedge that ends SERVE.
  - At that same edge, `mem_rData` is captured into the granted port's rData register, or zero on error.
  - Go to DONE.
- **DONE**
  - The granted port's ack is 1, and its err is 1 if the access was flagged.
  - The other port's rData register holds its previous value.
  - Go to IDLE unconditionally.
- Outside SERVE:
  - `mem_writeEnable` = 0.
  - `mem_addr`, `mem_wData` and `mem_dsize` hold the operand registers; dmem reads are harmless.
- A requester drops req in the cycle after ack. The IDLE cycle after DONE therefore never re-grants a completed transaction.
- If req falls before ack (protocol violation), the latched transaction still completes and is acked.

## Timing
- Reset values: state = IDLE, `last_grant` = 1 (so port 0 wins the first tie), all operand registers = 0, `ack0`/`ack1` = 0, `err0`/`err1` = 0, `rData0`/`rData1` = 0, `mem_writeEnable` = 0, `mem_addr`/`mem_wData` = 0, `mem_dsize` = 0.
- Latency: req sampled high in IDLE at cycle N → SERVE at N+1 → ack at N+2.
- Throughput: one transaction per 3 cycles. The next grant is decided in the IDLE cycle N+3.
- Both ports hold req continuously: grants alternate 0, 1, 0, 1…; neither port waits more than one transaction.
- Reset asserted mid-SERVE:
  - `mem_writeEnable` drops immediately (asynchronous); the store is not guaranteed.
  - No ack is issued.
  - After release, a still-high req is re-arbitrated from IDLE with `last_grant` = 1.
- Reset asserted in DONE: ack drops immediately.

## Configuration
- `DMEM_ARB_ALIGN_CHECK_EN` defined:
  - In IDLE, the latched access is flagged misaligned when:
    - word (dsize 3 or 2) and `addr[30:31]` ≠ 0, or
    - halfword (dsize 1) and `addr[31]` ≠ 0.
  - A flagged access suppresses `mem_writeEnable`, returns rData = 0, and pulses err with ack.
- `DMEM_ARB_ALIGN_CHECK_EN` undefined:
  - No check is made; every access is passed to dmem.
  - `err0`/`err1` are tied 0.
  - The ports exist in both builds.

## Test plan
- **Reset:** assert reset → every output reads 0. Release, then port 0 loads word at 0x100 (mem preloaded 0xDEADBEEF) → `ack0` 2 cycles after req, `rData0` = 0xDEADBEEF, `mem_writeEnable` never 1.
- **Store then load:** port 1 stores word 0x12345678 at 0x40 → `mem_writeEnable` = 1 for exactly one cycle (SERVE). Then port 1 loads 0x40 → `rData1` = 0x12345678.
- **Contention:** req0 and req1 both high from reset release with addresses 0x0 and 0x4 → grant order 0, 1, 0, 1; acks 3 cycles apart; no overlap; each rData matches its own address.
- **Misaligned store** (macro on): port 0 word store at 0x102 → `ack0` and `err0` high together, memory at 0x100–0x107 unchanged, `rData0` = 0. Macro off: same stimulus → `err0` = 0 and memory is written.
- **Reset mid-SERVE:** port 0 store to 0x80, reset pulsed during SERVE → no `ack0`. After release with req0 still high → fresh grant, `ack0` 2 cycles later.
